// File: rtl/mem_bist_ctrl.sv
// Memory built-in self-test initiator: writes pat^addr ascending, reads back descending,
// and reports pass, mismatch count and the first failing address in read order.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | strobes low, waiting for start
// S_WRITE | write exp(addr) at ascending addresses 0..max
// S_READ  | read descending addresses max..0, compare previous read
// S_DRAIN | strobes low, compare the last word read (address 0)
// S_DONE  | one-cycle done pulse, pass valid
module mem_bist_ctrl #(
    parameter int a_height = 4,
    parameter int d_width  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [d_width-1:0]  pat,
    output logic                mem_read,
    output logic                mem_wr,
    output logic [a_height-1:0] mem_addr,
    output logic [d_width-1:0]  mem_din,
    input  logic [d_width-1:0]  mem_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [a_height:0]   err_cnt,
    output logic [a_height-1:0] fail_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [a_height-1:0] ADDR_MAX  = '1;
    localparam logic [a_height-1:0] ADDR_ZERO = '0;
    localparam logic [a_height-1:0] ADDR_ONE  = a_height'(1);
    localparam logic [a_height:0]   ERR_MAX   = {1'b1, {a_height{1'b0}}};
    localparam logic [a_height:0]   ERR_ONE   = (a_height+1)'(1);

    state_t                state_q, state_d;
    logic [a_height-1:0]   addr_q, addr_d;
    logic [d_width-1:0]    pat_q, pat_d;
    logic                  cmp_vld_q, cmp_vld_d;
    logic [d_width-1:0]    cmp_exp_q, cmp_exp_d;
    logic [a_height-1:0]   cmp_addr_q, cmp_addr_d;
    logic [a_height:0]     err_cnt_q, err_cnt_d;
    logic [a_height-1:0]   fail_addr_q, fail_addr_d;
    logic                  pass_q, pass_d;

    logic [d_width-1:0]    addr_ext;
    logic [d_width-1:0]    exp_word;
    logic                  mismatch;

    // Address is zero-extended or truncated to the data width before the XOR.
    generate
        if (d_width > a_height) begin : g_addr_zext
            assign addr_ext = {{(d_width-a_height){1'b0}}, addr_q};
        end else if (d_width == a_height) begin : g_addr_same
            assign addr_ext = addr_q;
        end else begin : g_addr_trunc
            assign addr_ext = addr_q[d_width-1:0];
        end
    endgenerate

    assign exp_word = pat_q ^ addr_ext;
    assign mismatch = cmp_vld_q && (mem_out != cmp_exp_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pat_d       = pat_q;
        cmp_vld_d   = 1'b0;
        cmp_exp_d   = cmp_exp_q;
        cmp_addr_d  = cmp_addr_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        pass_d      = pass_q;
        mem_wr      = 1'b0;
        mem_read    = 1'b0;
        mem_din     = '0;
        busy        = 1'b0;
        done        = 1'b0;

        // Read data arrives one cycle after the strobe, so the compare trails the read.
        if (mismatch) begin
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERR_ONE;
            end
            if (err_cnt_q == '0) begin
                fail_addr_d = cmp_addr_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    pat_d       = pat;
                    addr_d      = ADDR_ZERO;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                    pass_d      = 1'b0;
                end
            end
            S_WRITE: begin
                mem_wr  = 1'b1;
                mem_din = exp_word;
                busy    = 1'b1;
                if (addr_q == ADDR_MAX) begin
                    state_d = S_READ;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_READ: begin
                mem_read   = 1'b1;
                busy       = 1'b1;
                cmp_vld_d  = 1'b1;
                cmp_exp_d  = exp_word;
                cmp_addr_d = addr_q;
                if (addr_q == ADDR_ZERO) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q - ADDR_ONE;
                end
            end
            S_DRAIN: begin
                busy    = 1'b1;
                state_d = S_DONE;
                pass_d  = (err_cnt_d == '0);
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            pat_q       <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pat_q       <= pat_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            pass_q      <= pass_d;
        end
    end

    assign mem_addr  = addr_q;
    assign err_cnt   = err_cnt_q;
    assign fail_addr = fail_addr_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Scoreboard bench for mem_bist_ctrl: 16x4 instance (A) and 8x8 instance (B), each
// against a behavioural memory with per-address read-fault masks.
module tb_mem_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en;

    logic       start_a, mem_read_a, mem_wr_a, busy_a, done_a, pass_a;
    logic [3:0] pat_a, mem_addr_a, mem_din_a, mem_out_a, fail_addr_a;
    logic [4:0] err_cnt_a;
    logic [3:0] mem_a [16];
    logic [3:0] flt_a [16];

    logic       start_b, mem_read_b, mem_wr_b, busy_b, done_b, pass_b;
    logic [7:0] pat_b, mem_din_b, mem_out_b;
    logic [2:0] mem_addr_b, fail_addr_b;
    logic [3:0] err_cnt_b;
    logic [7:0] mem_b [8];
    logic [7:0] flt_b [8];

    typedef struct {
        int pass;
        int err;
        int fail;
        int dc;
    } res_t;

    int   wr_a_q[$], rd_a_q[$], wr_b_q[$], rd_b_q[$];
    res_t res_a_q[$], res_b_q[$];

    mem_bist_ctrl #(.a_height(4), .d_width(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pat(pat_a),
        .mem_read(mem_read_a), .mem_wr(mem_wr_a), .mem_addr(mem_addr_a),
        .mem_din(mem_din_a), .mem_out(mem_out_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_cnt(err_cnt_a), .fail_addr(fail_addr_a)
    );

    mem_bist_ctrl #(.a_height(3), .d_width(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pat(pat_b),
        .mem_read(mem_read_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b),
        .mem_din(mem_din_b), .mem_out(mem_out_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_cnt(err_cnt_b), .fail_addr(fail_addr_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memories; the fault mask corrupts only the read path.
    always @(posedge clk) begin
        if (mem_wr_a) mem_a[mem_addr_a] <= mem_din_a;
        if (mem_read_a) mem_out_a <= mem_a[mem_addr_a] ^ flt_a[mem_addr_a];
        if (mem_wr_b) mem_b[mem_addr_b] <= mem_din_b;
        if (mem_read_b) mem_out_b <= mem_b[mem_addr_b] ^ flt_b[mem_addr_b];
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_a(input logic [3:0] p, input int nrd, input bit has_res,
                          input int ep, input int ee, input int ef, input int dc);
        res_t r;
        for (int a = 0; a < 16; a++) wr_a_q.push_back(a * 256 + int'(p ^ 4'(a)));
        for (int i = 0; i < nrd; i++) rd_a_q.push_back(15 - i);
        if (has_res) begin
            r.pass = ep; r.err = ee; r.fail = ef; r.dc = dc;
            res_a_q.push_back(r);
        end
    endtask

    task automatic push_b(input logic [7:0] p, input int ep, input int ee, input int ef,
                          input int dc);
        res_t r;
        for (int a = 0; a < 8; a++) wr_b_q.push_back(a * 256 + int'(p ^ 8'(a)));
        for (int i = 0; i < 8; i++) rd_b_q.push_back(7 - i);
        r.pass = ep; r.err = ee; r.fail = ef; r.dc = dc;
        res_b_q.push_back(r);
    endtask

    // Start asserted at negedge cyc=c is accepted at edge c+1; done is seen at cyc=c+34 (A) / c+18 (B).
    task automatic launch_a(input logic [3:0] p, input int ep, input int ee, input int ef);
        push_a(p, 16, 1'b1, ep, ee, ef, cyc + 34);
        pat_a = p; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic launch_b(input logic [7:0] p, input int ep, input int ee, input int ef);
        push_b(p, ep, ee, ef, cyc + 18);
        pat_b = p; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic hold_a(input int ep, input int ee, input int ef);
        check("hold_pass_a", pass_a, ep);
        check("hold_err_a", err_cnt_a, ee);
        check("hold_fail_a", fail_addr_a, ef);
        check("hold_busy_a", busy_a, 0);
    endtask

    task automatic hold_b(input int ep, input int ee, input int ef);
        check("hold_pass_b", pass_b, ep);
        check("hold_err_b", err_cnt_b, ee);
        check("hold_fail_b", fail_addr_b, ef);
        check("hold_busy_b", busy_b, 0);
    endtask

    always @(negedge clk) begin : mon_a
        int   v;
        res_t r;
        if (mon_en) begin
            if (mem_wr_a || mem_read_a) check("strobe_excl_a", int'(mem_wr_a & mem_read_a), 0);
            if (mem_wr_a) begin
                check("wr_expected_a", int'(wr_a_q.size() > 0), 1);
                if (wr_a_q.size() > 0) begin
                    v = wr_a_q.pop_front();
                    check("wr_addr_din_a", int'(mem_addr_a) * 256 + int'(mem_din_a), v);
                end
            end
            if (mem_read_a) begin
                check("rd_expected_a", int'(rd_a_q.size() > 0), 1);
                check("rd_busy_a", busy_a, 1);
                if (rd_a_q.size() > 0) begin
                    v = rd_a_q.pop_front();
                    check("rd_addr_a", mem_addr_a, v);
                end
            end
            if (done_a) begin
                check("done_expected_a", int'(res_a_q.size() > 0), 1);
                check("done_busy_a", busy_a, 0);
                if (res_a_q.size() > 0) begin
                    r = res_a_q.pop_front();
                    check("done_cycle_a", cyc, r.dc);
                    check("done_pass_a", pass_a, r.pass);
                    check("done_err_a", err_cnt_a, r.err);
                    check("done_fail_a", fail_addr_a, r.fail);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        int   v;
        res_t r;
        if (mon_en) begin
            if (mem_wr_b || mem_read_b) check("strobe_excl_b", int'(mem_wr_b & mem_read_b), 0);
            if (mem_wr_b) begin
                check("wr_expected_b", int'(wr_b_q.size() > 0), 1);
                if (wr_b_q.size() > 0) begin
                    v = wr_b_q.pop_front();
                    check("wr_addr_din_b", int'(mem_addr_b) * 256 + int'(mem_din_b), v);
                end
            end
            if (mem_read_b) begin
                check("rd_expected_b", int'(rd_b_q.size() > 0), 1);
                if (rd_b_q.size() > 0) begin
                    v = rd_b_q.pop_front();
                    check("rd_addr_b", mem_addr_b, v);
                end
            end
            if (done_b) begin
                check("done_expected_b", int'(res_b_q.size() > 0), 1);
                if (res_b_q.size() > 0) begin
                    r = res_b_q.pop_front();
                    check("done_cycle_b", cyc, r.dc);
                    check("done_pass_b", pass_b, r.pass);
                    check("done_err_b", err_cnt_b, r.err);
                    check("done_fail_b", fail_addr_b, r.fail);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; mon_en = 1'b0;
        start_a = 1'b0; pat_a = '0; start_b = 1'b0; pat_b = '0;
        for (int i = 0; i < 16; i++) flt_a[i] = '0;
        for (int i = 0; i < 8; i++) flt_b[i] = '0;
        repeat (3) @(negedge clk);

        check("rst_mem_read_a", mem_read_a, 0);
        check("rst_mem_wr_a", mem_wr_a, 0);
        check("rst_mem_addr_a", mem_addr_a, 0);
        check("rst_mem_din_a", mem_din_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_pass_a", pass_a, 0);
        check("rst_err_a", err_cnt_a, 0);
        check("rst_fail_a", fail_addr_a, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_err_b", err_cnt_b, 0);
        rst = 1'b0; mon_en = 1'b1;
        @(negedge clk);

        // Clean run, pat A.
        t = cyc; launch_a(4'hA, 1, 0, 0);
        wait_until(t + 37); hold_a(1, 0, 0);

        // Bit0 flipped at address 5.
        flt_a[5] = 4'h1;
        t = cyc; launch_a(4'h3, 0, 1, 5);
        wait_until(t + 37); hold_a(0, 1, 5);
        flt_a[5] = 4'h0;

        // Faults at 3 and 9: 9 is met first in descending order.
        flt_a[3] = 4'h8; flt_a[9] = 4'h2;
        t = cyc; launch_a(4'h7, 0, 2, 9);
        wait_until(t + 37); hold_a(0, 2, 9);
        flt_a[3] = 4'h0; flt_a[9] = 4'h0;

        // Every word bad: count reaches the full depth.
        for (int i = 0; i < 16; i++) flt_a[i] = 4'hF;
        t = cyc; launch_a(4'h0, 0, 16, 15);
        wait_until(t + 37); hold_a(0, 16, 15);
        for (int i = 0; i < 16; i++) flt_a[i] = 4'h0;

        // Start pulse mid-WRITE ignored; start held from late READ starts a second run.
        t = cyc; launch_a(4'h5, 1, 0, 0);
        wait_until(t + 6);
        check("s4_cleared_err", err_cnt_a, 0);
        check("s4_cleared_fail", fail_addr_a, 0);
        check("s4_busy", busy_a, 1);
        check("s4_wr", mem_wr_a, 1);
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        wait_until(t + 32);
        pat_a = 4'hC; start_a = 1'b1;
        push_a(4'hC, 16, 1'b1, 0, 1, 7, t + 69);
        wait_until(t + 38);
        check("s4_run2_pass_low", pass_a, 0);
        check("s4_run2_err", err_cnt_a, 0);
        check("s4_run2_busy", busy_a, 1);
        start_a = 1'b0;
        wait_until(t + 40); flt_a[7] = 4'h4;
        wait_until(t + 72); hold_a(0, 1, 7);
        flt_a[7] = 4'h0;

        // Reset on the 4th READ cycle; address 15 is faulted so status is non-zero first.
        flt_a[15] = 4'h1;
        t = cyc;
        push_a(4'h6, 4, 1'b0, 0, 0, 0, 0);
        pat_a = 4'h6; start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        wait_until(t + 20);
        check("s5_pre_err", err_cnt_a, 1);
        check("s5_pre_fail", fail_addr_a, 15);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("s5_mem_read", mem_read_a, 0);
        check("s5_mem_wr", mem_wr_a, 0);
        check("s5_busy", busy_a, 0);
        check("s5_done", done_a, 0);
        check("s5_pass", pass_a, 0);
        check("s5_err", err_cnt_a, 0);
        check("s5_fail", fail_addr_a, 0);
        check("s5_addr", mem_addr_a, 0);
        flt_a[15] = 4'h0;
        wait_until(t + 40);
        t = cyc; launch_a(4'h9, 1, 0, 0);
        wait_until(t + 37); hold_a(1, 0, 0);

        // 8x8 instance.
        t = cyc; launch_b(8'hF0, 1, 0, 0);
        wait_until(t + 21); hold_b(1, 0, 0);
        flt_b[2] = 8'h81;
        t = cyc; launch_b(8'h3C, 0, 1, 2);
        wait_until(t + 21); hold_b(0, 1, 2);
        for (int i = 0; i < 8; i++) flt_b[i] = 8'h55;
        t = cyc; launch_b(8'hFF, 0, 8, 7);
        wait_until(t + 21); hold_b(0, 8, 7);

        repeat (5) @(negedge clk);
        check("left_wr_a", wr_a_q.size(), 0);
        check("left_rd_a", rd_a_q.size(), 0);
        check("left_res_a", res_a_q.size(), 0);
        check("left_wr_b", wr_b_q.size(), 0);
        check("left_rd_b", rd_b_q.size(), 0);
        check("left_res_b", res_b_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
